booth_r4_mul: RTL



---
 rtl/booth_r4_mul.sv | 114 +++++++++++
 1 files changed

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier producing the full 2N-bit product of
// signed/unsigned operands, with a fixed data-independent latency.
module booth_r4_mul #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int EW   = N + 2;
  localparam int UW   = N + 4;
  localparam int PW   = UW + EW + 1;
  localparam int ITER = EW / 2;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [EW-1:0]   r_aExt;
  logic [PW-1:0]   r_p;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_product;

  logic [EW-1:0]   w_aExt;
  logic [EW-1:0]   w_bExt;
  logic [UW-1:0]   w_a4;
  logic [UW-1:0]   w_mult;
  logic [UW-1:0]   w_upperSum;
  logic [PW-1:0]   w_pAdded;
  logic [PW-1:0]   w_pShifted;
  logic            w_lastIter;

  // The extra sign bit keeps unsigned operands positive; two bits make the
  // operand length even so the digit count comes out integral.
  assign w_aExt = a_signed ? {{2{multiplicand[N-1]}}, multiplicand} : {2'b00, multiplicand};
  assign w_bExt = b_signed ? {{2{multiplier[N-1]}}, multiplier}     : {2'b00, multiplier};

  assign w_a4       = {{2{r_aExt[EW-1]}}, r_aExt};
  assign w_lastIter = (r_cnt == CW'(ITER));

  always_comb begin
    w_mult = '0;
    case (r_p[2:0])
      3'b001, 3'b010: w_mult = w_a4;
      3'b011:         w_mult = w_a4 << 1;
      3'b100:         w_mult = -(w_a4 << 1);
      3'b101, 3'b110: w_mult = -w_a4;
      default:        w_mult = '0;
    endcase
  end

  assign w_upperSum = r_p[PW-1 -: UW] + w_mult;
  assign w_pAdded   = {w_upperSum, r_p[EW:0]};
  assign w_pShifted = PW'($signed(w_pAdded) >>> 2);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUNNING;
      RUNNING: if (w_lastIter) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // After the last digit one settling cycle latches the product on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_aExt    <= '0;
      r_p       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_aExt <= w_aExt;
            r_p    <= {{UW{1'b0}}, w_bExt, 1'b0};
            r_cnt  <= '0;
          end
        end
        RUNNING: begin
          if (!w_lastIter) begin
            r_p   <= w_pShifted;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_product <= r_p[2*N:1];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign product = r_product;

endmodule
